// File: rtl/rq_pkg.sv
// rq_pkg: descriptor layout, FSM states and helpers shared by the RQ write splitter.
package rq_pkg;

  localparam int DESC_ADDR_LSB  = 2;
  localparam int DESC_ADDR_MSB  = 63;
  localparam int DESC_LEN_LSB   = 64;
  localparam int DESC_LEN_MSB   = 74;
  localparam int DESC_TYPE_LSB  = 75;
  localparam int DESC_TYPE_MSB  = 78;
  localparam int DESC_REQID_LSB = 80;
  localparam int DESC_REQID_MSB = 95;
  localparam int DESC_TAG_LSB   = 96;
  localparam int DESC_TAG_MSB   = 103;

  localparam logic [3:0] REQ_MEMWR = 4'b0001;
  localparam int LANES   = 8;
  localparam int DW_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAN = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Codes 6 and 7 are reserved and fall back to 4KB.
  function automatic logic [10:0] mps_to_dw(input logic [2:0] code);
    logic [10:0] dw;
    case (code)
      3'd0:    dw = 11'd32;
      3'd1:    dw = 11'd64;
      3'd2:    dw = 11'd128;
      3'd3:    dw = 11'd256;
      3'd4:    dw = 11'd512;
      default: dw = 11'd1024;
    endcase
    return dw;
  endfunction

  function automatic logic [127:0] pack_desc(
    input logic [61:0] addr_dw,
    input logic [10:0] len,
    input logic [15:0] req_id,
    input logic [7:0]  tag
  );
    logic [127:0] d;
    d = '0;
    d[DESC_ADDR_MSB:DESC_ADDR_LSB]   = addr_dw;
    d[DESC_LEN_MSB:DESC_LEN_LSB]     = len;
    d[DESC_TYPE_MSB:DESC_TYPE_LSB]   = REQ_MEMWR;
    d[DESC_REQID_MSB:DESC_REQID_LSB] = req_id;
    d[DESC_TAG_MSB:DESC_TAG_LSB]     = tag;
    return d;
  endfunction

endpackage

// File: rtl/rq_tlp_len_calc.sv
// rq_tlp_len_calc: next TLP length = min(remaining, MPS, DWs to the 4KB boundary),
// plus the number of 256-bit beats that length occupies.
module rq_tlp_len_calc #(
  parameter int LEN_W = 16
) (
  input  logic [LEN_W-1:0] rem_i,
  input  logic [10:0]      mps_dw_i,
  input  logic [11:0]      addr_lo_i,
  output logic [10:0]      tlp_len_o,
  output logic [7:0]       beats_o
);

  localparam int CW = (LEN_W > 13) ? LEN_W : 13;

  logic [12:0]   bnd_dw;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] mps_w;
  logic [CW-1:0] bnd_w;
  logic [CW-1:0] min_a;
  logic [CW-1:0] min_b;

  // A page-aligned address yields a full 1024 DW of room.
  assign bnd_dw = (13'd4096 - {1'b0, addr_lo_i}) >> 2;

  assign rem_w = CW'(rem_i);
  assign mps_w = CW'(mps_dw_i);
  assign bnd_w = CW'(bnd_dw);

  assign min_a = (rem_w < mps_w) ? rem_w : mps_w;
  assign min_b = (min_a < bnd_w) ? min_a : bnd_w;

  assign tlp_len_o = 11'(min_b);
  assign beats_o   = 8'((tlp_len_o + 11'd7) >> 3);

endmodule

// File: rtl/rq_wr_splitter.sv
// rq_wr_splitter: splits a write command into MPS/4KB-bounded MemWr TLPs for the RQ gearbox.
// Build option RQ_SPLIT_TAG_EN: per-TLP wrapping tag counter; otherwise the tag is always 0.
module rq_wr_splitter
  import rq_pkg::*;
#(
  parameter int          DATA_WIDTH = 256,
  parameter int          LEN_W      = 16,
  parameter logic [15:0] REQ_ID     = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            cfg_mps,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [63:0]           cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len_dw,
  output logic                  addr_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [127:0]          descriptor,
  output logic [DATA_WIDTH-1:0] rq_payload,
  output logic [10:0]           rq_payload_dw_count,
  output logic                  rq_payload_sop,
  output logic                  rq_payload_last,
  output logic                  rq_valid,
  input  logic                  rq_ready,
  output logic                  busy
);

  state_e                state_q;
  logic [63:0]           cur_addr_q;
  logic [LEN_W-1:0]      rem_q;
  logic [LEN_W-1:0]      rem_d;
  logic [10:0]           mps_dw_q;
  logic [10:0]           tlp_len_q;
  logic [7:0]            beats_q;
  logic [7:0]            beat_cnt_q;
  logic [7:0]            tag_q;
  logic                  addr_err_q;

  logic [127:0]          desc_q;
  logic [DATA_WIDTH-1:0] payload_q;
  logic [DATA_WIDTH-1:0] payload_d;
  logic [10:0]           dw_cnt_q;
  logic                  sop_q;
  logic                  last_q;
  logic                  rq_valid_q;

  logic [10:0]           calc_len;
  logic [7:0]            calc_beats;
  logic                  out_adv;
  logic                  in_fire;
  logic                  is_last;
  logic [3:0]            keep_lanes;

  rq_tlp_len_calc #(.LEN_W(LEN_W)) u_len_calc (
    .rem_i     (rem_q),
    .mps_dw_i  (mps_dw_q),
    .addr_lo_i (cur_addr_q[11:0]),
    .tlp_len_o (calc_len),
    .beats_o   (calc_beats)
  );

  assign out_adv   = !rq_valid_q || rq_ready;
  assign in_ready  = (state_q == ST_XFER) && out_adv;
  assign in_fire   = in_valid && in_ready;
  assign is_last   = (beat_cnt_q == beats_q - 8'd1);
  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign rem_d     = rem_q - LEN_W'(tlp_len_q);

  // Number of live DW lanes in the final beat of a TLP (1..8).
  assign keep_lanes = (tlp_len_q[2:0] == 3'd0) ? 4'd8 : {1'b0, tlp_len_q[2:0]};

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign payload_d[gi*DW_BITS +: DW_BITS] =
      (!is_last || (4'(gi) < keep_lanes)) ? in_data[gi*DW_BITS +: DW_BITS] : '0;
  end

`ifdef RQ_SPLIT_TAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= 8'h00;
    end else if (in_fire && is_last) begin
      tag_q <= tag_q + 8'h01;
    end
  end
`else
  assign tag_q = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      mps_dw_q   <= '0;
      tlp_len_q  <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      addr_err_q <= 1'b0;
      desc_q     <= '0;
      payload_q  <= '0;
      dw_cnt_q   <= '0;
      sop_q      <= 1'b0;
      last_q     <= 1'b0;
      rq_valid_q <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            cur_addr_q <= {cmd_addr[63:5], 5'b0};
            rem_q      <= cmd_len_dw;
            mps_dw_q   <= mps_to_dw(cfg_mps);
            addr_err_q <= |cmd_addr[4:0];
            if (cmd_len_dw != '0) state_q <= ST_PLAN;
          end
        end
        ST_PLAN: begin
          tlp_len_q  <= calc_len;
          beats_q    <= calc_beats;
          beat_cnt_q <= 8'd0;
          state_q    <= ST_XFER;
        end
        ST_XFER: begin
          if (in_fire) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (is_last) begin
              cur_addr_q <= cur_addr_q + {51'd0, tlp_len_q, 2'b00};
              rem_q      <= rem_d;
              state_q    <= (rem_d != '0) ? ST_PLAN : ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Output stage: holds while stalled, otherwise loads a beat or drains.
      if (out_adv) begin
        rq_valid_q <= in_fire;
        if (in_fire) begin
          desc_q    <= pack_desc(cur_addr_q[63:2], tlp_len_q, REQ_ID, tag_q);
          payload_q <= payload_d;
          dw_cnt_q  <= tlp_len_q;
          sop_q     <= (beat_cnt_q == 8'd0);
          last_q    <= is_last;
        end
      end
    end
  end

  assign addr_err            = addr_err_q;
  assign descriptor          = desc_q;
  assign rq_payload          = payload_q;
  assign rq_payload_dw_count = dw_cnt_q;
  assign rq_payload_sop      = sop_q;
  assign rq_payload_last     = last_q;
  assign rq_valid            = rq_valid_q;

endmodule
